// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_cmd_pkg : shared constants, codes and state encoding for the        |
// |                UART command controller.               rev 1.0            |
// +--------------------------------------------------------------------------+
package uart_cmd_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t HDR_CMD = 8'hA5;
    localparam byte_t HDR_RSP = 8'h5A;

    localparam byte_t CMD_WRITE = 8'h01;
    localparam byte_t CMD_READ  = 8'h02;

    localparam byte_t STATUS_OK         = 8'h00;
    localparam byte_t STATUS_CSUM_ERR   = 8'h01;
    localparam byte_t STATUS_BAD_CMD    = 8'h02;
    localparam byte_t STATUS_RD_TIMEOUT = 8'h03;

    localparam int GAP_W = 18;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_EXEC   = 3'd5,
        ST_RDWAIT = 3'd6,
        ST_RESP   = 3'd7
    } state_t;

    function automatic logic csum_match(input byte_t cmd, input byte_t addr,
                                        input byte_t data, input byte_t csum);
        return (cmd ^ addr ^ data) == csum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_byte_fetch : pop/capture handshake with the UART driver RX buffer.  |
// |                                                        rev 1.0           |
// +--------------------------------------------------------------------------+
module uart_byte_fetch
    import uart_cmd_pkg::*;
(
    input  logic  clk_in,
    input  logic  rst_n,
    input  logic  enable,
    input  logic  rx_ready,
    output logic  rx_trigger,
    input  byte_t rx_data,
    output logic  byte_valid,
    output byte_t byte_data
);

    logic pending_q;
    logic pending_d;

    // A pop is outstanding for exactly one cycle, which also keeps the
    // strobe from ever firing on back-to-back cycles.
    always_comb begin
        rx_trigger = rst_n && enable && rx_ready && !pending_q;
        pending_d  = rx_trigger;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign byte_valid = pending_q;
    assign byte_data  = rx_data;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_cmd_ctrl : assembles 5-byte command frames, executes register       |
// |                 accesses and returns 3-byte responses.     rev 1.0       |
// +--------------------------------------------------------------------------+
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int CMD_TIMEOUT = 240000,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       rx_ready,
    output logic       rx_trigger,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_trigger,
    output logic [7:0] tx_data,
    output logic       reg_wr,
    output logic       reg_rd,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    input  logic       reg_rvalid,
    output logic       busy
);

    localparam int              RD_W      = $clog2(RD_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(CMD_TIMEOUT);
    localparam logic [RD_W-1:0]  RD_LIMIT  = RD_W'(RD_TIMEOUT - 1);

    state_t           state_q,     state_d;
    byte_t            cmd_q,       cmd_d;
    byte_t            reg_addr_q,  reg_addr_d;
    byte_t            reg_wdata_q, reg_wdata_d;
    byte_t            csum_q,      csum_d;
    byte_t            status_q,    status_d;
    byte_t            rdata_q,     rdata_d;
    logic [GAP_W-1:0] gap_q,       gap_d;
    logic [RD_W-1:0]  rd_cnt_q,    rd_cnt_d;
    logic [1:0]       resp_idx_q,  resp_idx_d;
    logic             push_q,      push_d;

    logic  fetch_en;
    logic  byte_valid;
    byte_t byte_data;
    logic  in_frame;
    logic  gap_expired;
    logic  wr_fire;
    logic  rd_fire;
    logic  tx_fire;
    byte_t tx_byte;

    assign fetch_en = (state_q == ST_HUNT) || (state_q == ST_CMD) ||
                      (state_q == ST_ADDR) || (state_q == ST_DATA) ||
                      (state_q == ST_CSUM);
    assign in_frame = fetch_en && (state_q != ST_HUNT);

    uart_byte_fetch u_fetch (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .enable     (fetch_en),
        .rx_ready   (rx_ready),
        .rx_trigger (rx_trigger),
        .rx_data    (rx_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        csum_d      = csum_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        gap_d       = '0;
        rd_cnt_d    = '0;
        resp_idx_d  = resp_idx_q;
        push_d      = 1'b0;
        wr_fire     = 1'b0;
        rd_fire     = 1'b0;
        tx_fire     = 1'b0;
        tx_byte     = 8'h00;
        gap_expired = 1'b0;

        // Gap counter saturates rather than wrapping on a stalled link.
        if (in_frame && !byte_valid) begin
            gap_expired = (gap_q >= GAP_LIMIT);
            gap_d       = (gap_q == '1) ? gap_q : gap_q + GAP_W'(1);
        end

        case (state_q)
            ST_HUNT: begin
                if (byte_valid && (byte_data == HDR_CMD)) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (byte_valid) begin
                    cmd_d   = byte_data;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (byte_valid) begin
                    reg_addr_d = byte_data;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (byte_valid) begin
                    reg_wdata_d = byte_data;
                    state_d     = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (byte_valid) begin
                    csum_d  = byte_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rdata_d = 8'h00;
                state_d = ST_RESP;
                if (!csum_match(cmd_q, reg_addr_q, reg_wdata_q, csum_q)) begin
                    status_d = STATUS_CSUM_ERR;
                end else if (cmd_q == CMD_WRITE) begin
                    wr_fire  = 1'b1;
                    status_d = STATUS_OK;
                end else if (cmd_q == CMD_READ) begin
                    rd_fire  = 1'b1;
                    state_d  = ST_RDWAIT;
                end else begin
                    status_d = STATUS_BAD_CMD;
                end
            end
            ST_RDWAIT: begin
                if (reg_rvalid) begin
                    rdata_d  = reg_rdata;
                    status_d = STATUS_OK;
                    state_d  = ST_RESP;
                end else if (rd_cnt_q == RD_LIMIT) begin
                    status_d = STATUS_RD_TIMEOUT;
                    state_d  = ST_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q + RD_W'(1);
                end
            end
            ST_RESP: begin
                case (resp_idx_q)
                    2'd0:    tx_byte = HDR_RSP;
                    2'd1:    tx_byte = status_q;
                    default: tx_byte = rdata_q;
                endcase
                // push_q forces an idle cycle after every push.
                if (tx_ready && !push_q) begin
                    tx_fire = 1'b1;
                    push_d  = 1'b1;
                    if (resp_idx_q == 2'd2) begin
                        resp_idx_d = 2'd0;
                        state_d    = ST_HUNT;
                    end else begin
                        resp_idx_d = resp_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        if (gap_expired) begin
            state_d = ST_HUNT;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            cmd_q       <= 8'h00;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            csum_q      <= 8'h00;
            status_q    <= 8'h00;
            rdata_q     <= 8'h00;
            gap_q       <= '0;
            rd_cnt_q    <= '0;
            resp_idx_q  <= 2'd0;
            push_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            csum_q      <= csum_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            gap_q       <= gap_d;
            rd_cnt_q    <= rd_cnt_d;
            resp_idx_q  <= resp_idx_d;
            push_q      <= push_d;
        end
    end

    // Strobes are gated by reset so an abort takes effect in the same cycle.
    assign reg_wr     = rst_n && wr_fire;
    assign reg_rd     = rst_n && rd_fire;
    assign tx_trigger = rst_n && tx_fire;
    assign tx_data    = tx_byte;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign busy       = (state_q != ST_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_uart_cmd_ctrl : directed and randomized frames against a behavioural  |
// |                    response model.                    rev 1.0            |
// +--------------------------------------------------------------------------+
module tb_uart_cmd_ctrl;

    localparam int CMD_TO = 60;
    localparam int RD_TO  = 255;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx_ready = 1'b0;
    logic       rx_trigger;
    logic [7:0] rx_data = 8'h00;
    logic       tx_ready = 1'b1;
    logic       tx_trigger;
    logic [7:0] tx_data;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_rvalid = 1'b0;
    logic       busy;

    uart_cmd_ctrl #(
        .CMD_TIMEOUT (CMD_TO),
        .RD_TIMEOUT  (RD_TO)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .rx_ready   (rx_ready),
        .rx_trigger (rx_trigger),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_trigger (tx_trigger),
        .tx_data    (tx_data),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Stimulus knobs written only by the main sequence.
    logic [7:0] rx_buf[$];
    int         rd_delay = 0;
    logic [7:0] rd_val   = 8'h00;
    bit         tx_hold  = 1'b0;
    bit         tx_rand  = 1'b0;

    // Observations written only by the monitor.
    logic [7:0]  tx_got[$];
    int          tx_cyc[$];
    logic [15:0] wr_log[$];
    int          wr_cyc[$];
    logic [7:0]  rd_log[$];
    int          rd_seen = 0;
    int          rx_pop_req = 0;
    int          last_rx_trig_cyc = 0;
    int          rx_viol = 0;
    int          tx_viol = 0;
    bit          prev_rx = 1'b0;
    bit          prev_tx = 1'b0;

    always @(negedge clk_in) begin
        if (rx_trigger) begin
            if (prev_rx || !rx_ready) rx_viol++;
            rx_pop_req++;
            last_rx_trig_cyc = cyc;
        end
        prev_rx = rx_trigger;
        if (tx_trigger) begin
            if (prev_tx || !tx_ready) tx_viol++;
            tx_got.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
        prev_tx = tx_trigger;
        if (reg_wr) begin
            wr_log.push_back({reg_addr, reg_wdata});
            wr_cyc.push_back(cyc);
        end
        if (reg_rd) begin
            rd_log.push_back(reg_addr);
            rd_seen++;
        end
    end

    // RX buffer model: popped byte appears on rx_data the cycle after the strobe.
    int rx_idx = 0;
    always @(posedge clk_in) begin
        #1;
        if (rx_idx < rx_pop_req) begin
            if (rx_idx < rx_buf.size()) rx_data = rx_buf[rx_idx];
            rx_idx++;
        end
        rx_ready = (rx_idx < rx_buf.size());
    end

    // Register bus model: reg_rvalid lands rd_delay cycles after reg_rd (0 = never).
    int rd_handled = 0;
    int rd_cnt     = 0;
    always @(posedge clk_in) begin
        #1;
        reg_rvalid = 1'b0;
        if (rd_handled < rd_seen) begin
            rd_handled++;
            rd_cnt = rd_delay;
        end
        if (rd_cnt > 0) begin
            if (rd_cnt == 1) begin
                reg_rvalid = 1'b1;
                reg_rdata  = rd_val;
            end
            rd_cnt--;
        end
    end

    always @(posedge clk_in) begin
        #1;
        if (tx_hold)      tx_ready = 1'b0;
        else if (tx_rand) tx_ready = ($urandom_range(0, 1) == 1);
        else              tx_ready = 1'b1;
    end

    task automatic check1(input string tag, input logic got, input logic exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic checki(input string tag, input int got, input int exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected outcome of one frame, straight from the command rules.
    function automatic void model(input logic [7:0] c, input logic [7:0] a,
                                  input logic [7:0] d, input logic [7:0] s,
                                  input int delay, input logic [7:0] rv,
                                  output logic [7:0] st, output logic [7:0] rd,
                                  output bit wr);
        wr = 1'b0;
        rd = 8'h00;
        if ((c ^ a ^ d) != s)       st = 8'h01;
        else if (c == 8'h01) begin  st = 8'h00; wr = 1'b1; end
        else if (c == 8'h02) begin
            if (delay >= 1 && delay <= RD_TO) begin st = 8'h00; rd = rv; end
            else st = 8'h03;
        end
        else                        st = 8'h02;
    endfunction

    task automatic run_frame(input string tag, input int njunk,
                             input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] s,
                             input int delay, input logic [7:0] rv, input int hold);
        logic [7:0] e_st, e_rd, jb;
        bit         e_wr;
        int         wr0, rd0, tx0, t;
        model(c, a, d, s, delay, rv, e_st, e_rd, e_wr);
        rd_delay = delay;
        rd_val   = rv;
        wr0 = wr_log.size();
        rd0 = rd_log.size();
        tx0 = tx_got.size();
        if (hold > 0) tx_hold = 1'b1;
        for (int j = 0; j < njunk; j++) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'hA5) jb = 8'h00;
            rx_buf.push_back(jb);
        end
        rx_buf.push_back(8'hA5);
        rx_buf.push_back(c);
        rx_buf.push_back(a);
        rx_buf.push_back(d);
        rx_buf.push_back(s);
        if (hold > 0) begin
            repeat (hold) @(negedge clk_in);
            checki({tag, ".held_tx"}, tx_got.size() - tx0, 0);
            check1({tag, ".held_busy"}, busy, 1'b1);
            tx_hold = 1'b0;
        end
        t = 0;
        while (tx_got.size() < tx0 + 3 && t < 3000) begin
            @(negedge clk_in);
            t++;
        end
        checki({tag, ".resp_len"}, tx_got.size() - tx0, 3);
        if (tx_got.size() >= tx0 + 3) begin
            check8({tag, ".hdr"},    tx_got[tx0],     8'h5A);
            check8({tag, ".status"}, tx_got[tx0 + 1], e_st);
            check8({tag, ".rdata"},  tx_got[tx0 + 2], e_rd);
        end
        repeat (2) @(negedge clk_in);
        check1({tag, ".idle"}, busy, 1'b0);
        checki({tag, ".wr_cnt"}, wr_log.size() - wr0, e_wr ? 1 : 0);
        if (e_wr && wr_log.size() > wr0) begin
            check8({tag, ".wr_addr"}, wr_log[wr0][15:8], a);
            check8({tag, ".wr_data"}, wr_log[wr0][7:0],  d);
        end
        if ((c ^ a ^ d) == s && c == 8'h02 && rd_log.size() > rd0)
            check8({tag, ".rd_addr"}, rd_log[rd0], a);
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         tx0, wr0;
        logic [7:0] c, a, d, s, rv;
        int         r, dly;

        // A byte waits in the RX buffer throughout reset.
        rx_buf.push_back(8'h11);
        repeat (3) @(negedge clk_in);
        check1("rst.rx_trigger", rx_trigger, 1'b0);
        check1("rst.tx_trigger", tx_trigger, 1'b0);
        check1("rst.reg_wr", reg_wr, 1'b0);
        check1("rst.reg_rd", reg_rd, 1'b0);
        check1("rst.busy", busy, 1'b0);
        check8("rst.tx_data", tx_data, 8'h00);
        check8("rst.reg_addr", reg_addr, 8'h00);
        check8("rst.reg_wdata", reg_wdata, 8'h00);
        rst_n = 1'b1;
        repeat (6) @(negedge clk_in);
        checki("hunt.junk_popped", rx_idx, 1);
        check1("hunt.junk_idle", busy, 1'b0);

        run_frame("wr", 0, 8'h01, 8'h10, 8'h3C, 8'h2D, 0, 8'h00, 0);
        if (wr_cyc.size() > 0 && tx_cyc.size() > 0) begin
            checki("wr.latency", wr_cyc[0] - last_rx_trig_cyc, 2);
            check1("wr.tx_after_wr", tx_cyc[0] > wr_cyc[0], 1'b1);
        end
        run_frame("rd", 0, 8'h02, 8'h22, 8'h00, 8'h20, 3, 8'h7E, 0);
        run_frame("csum", 0, 8'h01, 8'h10, 8'h3C, 8'h00, 0, 8'h00, 0);
        rx_buf.push_back(8'h00);
        rx_buf.push_back(8'hFF);
        run_frame("badcmd", 0, 8'h07, 8'h01, 8'h02, 8'h04, 0, 8'h00, 0);
        run_frame("midA5", 0, 8'h01, 8'hA5, 8'h3C, 8'h98, 0, 8'h00, 0);
        run_frame("rd_to", 0, 8'h02, 8'h33, 8'h00, 8'h31, 0, 8'h00, 0);
        run_frame("rd_255", 0, 8'h02, 8'h44, 8'h55, 8'h13, 255, 8'hC3, 0);
        run_frame("rd_256", 0, 8'h02, 8'h44, 8'h55, 8'h13, 256, 8'hC3, 0);

        // Stalled partial frame is dropped silently.
        tx0 = tx_got.size();
        wr0 = wr_log.size();
        rx_buf.push_back(8'hA5);
        rx_buf.push_back(8'h01);
        repeat (20) @(negedge clk_in);
        check1("gap.busy_mid", busy, 1'b1);
        repeat (CMD_TO + 10) @(negedge clk_in);
        check1("gap.busy_fell", busy, 1'b0);
        checki("gap.no_resp", tx_got.size() - tx0, 0);
        checki("gap.no_wr", wr_log.size() - wr0, 0);
        run_frame("after_gap", 0, 8'h01, 8'h5C, 8'h81, 8'hDC, 0, 8'h00, 0);

        run_frame("txhold", 1, 8'h02, 8'h40, 8'h11, 8'h53, 5, 8'h9C, 40);

        // Reset while the response is stuck behind tx_ready.
        tx0 = tx_got.size();
        wr0 = wr_log.size();
        tx_hold = 1'b1;
        rx_buf.push_back(8'hA5);
        rx_buf.push_back(8'h01);
        rx_buf.push_back(8'h33);
        rx_buf.push_back(8'h44);
        rx_buf.push_back(8'h76);
        repeat (30) @(negedge clk_in);
        check1("rstmid.busy", busy, 1'b1);
        checki("rstmid.wr_done", wr_log.size() - wr0, 1);
        rst_n = 1'b0;
        @(negedge clk_in);
        check1("rstmid.busy_cleared", busy, 1'b0);
        tx_hold = 1'b0;
        repeat (2) @(negedge clk_in);
        check1("rstmid.tx_quiet", tx_trigger, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_in);
        checki("rstmid.no_resp", tx_got.size() - tx0, 0);
        run_frame("after_rst", 0, 8'h01, 8'h01, 8'h02, 8'h02, 0, 8'h00, 0);

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 7);
            a  = 8'($urandom_range(0, 255));
            d  = 8'($urandom_range(0, 255));
            rv = 8'($urandom_range(0, 255));
            if (r < 3)      c = 8'h01;
            else if (r < 6) c = 8'h02;
            else            c = 8'($urandom_range(0, 255));
            s = c ^ a ^ d;
            if ($urandom_range(0, 4) == 0) s = s ^ 8'($urandom_range(1, 255));
            r = $urandom_range(0, 9);
            if (r == 0)      dly = 0;
            else if (r == 1) dly = 256;
            else             dly = $urandom_range(1, 40);
            tx_rand = ($urandom_range(0, 1) == 1);
            run_frame($sformatf("rnd%0d", i), $urandom_range(0, 2), c, a, d, s, dly, rv, 0);
        end
        tx_rand = 1'b0;

        checki("end.rx_handshake", rx_viol, 0);
        checki("end.tx_handshake", tx_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command controller sitting on the user side of the UART driver. Pops received bytes from the driver's RX buffer, assembles fixed 5-byte command frames, and validates them. Valid frames are executed as single-byte register writes or reads on the display-controller configuration bus. A 3-byte response frame is pushed into the driver's TX buffer for every complete frame, whether valid or invalid.

## Interface
- CMD_TIMEOUT, default 240000: max clk_in cycles between consecutive frame bytes (10 ms at 24 MHz) before the partial frame is discarded.
- RD_TIMEOUT, default 255: max cycles to wait for reg_rvalid after reg_rd.
- clk_in  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- rx_ready  in  1  driver RX buffer non-empty.
- rx_trigger  out  1  one-cycle pop strobe; byte is valid on rx_data the following cycle.
- rx_data  in  8  popped byte.
- tx_ready  in  1  driver TX buffer not full.
- tx_trigger  out  1  one-cycle push strobe.
- tx_data  out  8  byte pushed, qualified by tx_trigger.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_addr  out  8  register address, held from EXEC until return to HUNT.
- reg_wdata  out  8  write data, held as reg_addr.
- reg_rdata  in  8  read data, qualified by reg_rvalid.
- reg_rvalid  in  1  read-data valid pulse.
- busy  out  1  high in any state other than HUNT.

## Operation
- Command frame: 0xA5, CMD, ADDR, DATA, CSUM. CSUM = CMD ^ ADDR ^ DATA.
- CMD 0x01 = write. CMD 0x02 = read; DATA is ignored but still included in CSUM.
- Response frame: 0x5A, STATUS, RDATA.
  - STATUS: 0x00 OK, 0x01 checksum error, 0x02 unknown CMD, 0x03 read timeout.
  - RDATA is reg_rdata for an OK read, 0x00 otherwise.
- States: HUNT, CMD, ADDR, DATA, CSUM, EXEC, RDWAIT, RESP.
- Byte fetch in every receive state: when rx_ready is high and no fetch is outstanding, pulse rx_trigger; sample rx_data on the next cycle.
- HUNT: any byte other than 0xA5 is discarded with no response. 0xA5 goes to CMD.
- CMD, ADDR, DATA, CSUM each store one byte, then advance.
- EXEC, priority order:
  1. Checksum mismatch gives STATUS 0x01, even if CMD is also unknown.
  2. Unknown CMD gives STATUS 0x02.
  3. Write: pulse reg_wr, STATUS 0x00.
  4. Read: pulse reg_rd, go to RDWAIT.
- RDWAIT: reg_rvalid latches reg_rdata and sets STATUS 0x00. If RD_TIMEOUT cycles pass without reg_rvalid, STATUS is 0x03. Either way, go to RESP.
- RESP: push the 3 response bytes in order, each only when tx_ready is high, with at least one idle cycle between pushes. After the third push, return to HUNT.
- Inter-byte timeout: a gap counter runs in CMD, ADDR, DATA and CSUM and clears on each received byte. When it reaches CMD_TIMEOUT, return to HUNT with no response.
- A 0xA5 received mid-frame is treated as ordinary data; frames do not resync.
- Bytes arriving during EXEC, RDWAIT or RESP stay in the driver's buffer until HUNT.

## Timing
- Reset values: all strobes 0; tx_data, reg_addr, reg_wdata 0x00; busy 0; state HUNT; all counters 0.
- rx_trigger is never asserted on two consecutive cycles.
- Write path: the cycle after the CSUM byte is sampled, reg_wr pulses (EXEC). The first tx_trigger can come no earlier than the following cycle.
- Read path: reg_rd pulses in EXEC. reg_rvalid is accepted starting the cycle after reg_rd. The timeout count starts in the same cycle.
- Reset asserted mid-frame or mid-response: abort immediately to the reset state. A partially pushed response is not completed.
- The gap counter is 18 bits wide and saturates. It does not wrap.

## Structure
- Shared package uart_cmd_pkg holds:
  - header constants 0xA5 and 0x5A;
  - CMD codes;
  - STATUS codes;
  - the state enumeration.
- One sub-module, uart_byte_fetch, owns the rx_trigger/capture handshake. It outputs byte_valid and byte for one cycle per byte.

## Test plan
- Write frame A5 01 10 3C 2D → reg_wr pulse with reg_addr 0x10, reg_wdata 0x3C; TX emits 5A 00 00.
- Read frame A5 02 22 00 20, reg_rvalid with 0x7E three cycles after reg_rd → TX emits 5A 00 7E.
- Checksum error A5 01 10 3C 00 → no reg_wr; TX emits 5A 01 00.
- Junk 00 FF then A5 07 01 02 04 → junk silently dropped; TX emits 5A 02 00.
- Read with no reg_rvalid → after 255 cycles TX emits 5A 03 00. Separately, A5 01 then a stall longer than CMD_TIMEOUT → no response, busy falls. A following valid frame then works normally.
- tx_ready held low during RESP → no tx_trigger until tx_ready rises. All three response bytes are then pushed in order.
